// File: rtl/address_decode_regbank.sv
// Register bank with a built-in byte-address decoder and a valid/ready request/response port.
// Each register drives a slice of a flat output bus plus a one-cycle write pulse.
module address_decode_regbank #(
    parameter logic [31:0]              OFFSET        = 32'h0,
    parameter int unsigned              ADDRESS_STEP  = 4,
    parameter int unsigned              NUM_ADDRESSES = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE   = '0,
    parameter logic [NUM_ADDRESSES-1:0] RO_MASK       = '0
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_req_valid,
    output logic                                  o_req_ready,
    input  logic                                  i_req_write,
    input  logic [31:0]                           i_address,
    input  logic [DATA_WIDTH-1:0]                 i_write_data,
    input  logic [DATA_WIDTH/8-1:0]               i_write_strobe,
    output logic                                  o_resp_valid,
    input  logic                                  i_resp_ready,
    output logic [DATA_WIDTH-1:0]                 o_resp_data,
    output logic                                  o_resp_error,
    output logic [NUM_ADDRESSES*DATA_WIDTH-1:0]   o_reg_values,
    output logic [NUM_ADDRESSES-1:0]              o_write_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_ADDRESSES > 1) ? $clog2(NUM_ADDRESSES) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic                    r_resp_error;
    logic [NUM_ADDRESSES-1:0] r_write_pulse;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_ADDRESSES];

    logic [31:0]             w_delta;
    logic [31:0]             w_quot;
    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_ro;
    logic                    w_accept;
    logic                    w_wr_en;

    // Full 32-bit decode: the >= test stops addresses below OFFSET from wrapping into a hit.
    always_comb begin
        w_delta  = i_address - OFFSET;
        w_quot   = w_delta / 32'(ADDRESS_STEP);
        w_hit    = (i_address >= OFFSET) &&
                   ((w_delta % 32'(ADDRESS_STEP)) == 32'd0) &&
                   (w_quot < 32'(NUM_ADDRESSES));
        w_idx    = IDX_W'(w_quot);
        w_ro     = w_hit ? RO_MASK[w_idx] : 1'b1;
        w_accept = (r_state == ST_IDLE) && i_req_valid;
        w_wr_en  = w_accept && i_req_write && w_hit && !w_ro;
    end

    // Request/response handshake FSM with registered response and pulse outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_error  <= 1'b0;
            r_write_pulse <= '0;
        end else begin
            r_write_pulse <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_state      <= ST_RESP;
                        r_req_ready  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= !w_hit || (i_req_write && w_ro);
                        r_resp_data  <= (!i_req_write && w_hit) ? r_regs[w_idx] : '0;
                        if (w_wr_en) begin
                            r_write_pulse[w_idx] <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_data  <= '0;
                        r_resp_error <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register storage with byte-strobed writes at the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_ADDRESSES); i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_write_strobe[b]) begin
                    r_regs[w_idx][b*8 +: 8] <= i_write_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_ADDRESSES); g++) begin : g_flat
        assign o_reg_values[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign o_req_ready   = r_req_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_data   = r_resp_data;
    assign o_resp_error  = r_resp_error;
    assign o_write_pulse = r_write_pulse;

endmodule

// File: tb/tb_address_decode_regbank.sv
// Directed bench for address_decode_regbank: two instances (OFFSET 0 with RO reg 2, OFFSET 0x100 with 4 regs)
// share the request inputs; each check compares against hand-computed values.
module tb_address_decode_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        resp_ready;

    logic          a_req_ready, a_resp_valid, a_resp_error;
    logic [31:0]   a_resp_data;
    logic [1023:0] a_reg_values;
    logic [31:0]   a_write_pulse;

    logic          b_req_ready, b_resp_valid, b_resp_error;
    logic [31:0]   b_resp_data;
    logic [127:0]  b_reg_values;
    logic [3:0]    b_write_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Values captured one step after the accept edge
    logic [31:0] c_a_data, c_b_data, c_a_pulse;
    logic        c_a_err, c_b_err, c_a_valid;

    always #5 clk = ~clk;

    address_decode_regbank #(
        .OFFSET(32'h0), .ADDRESS_STEP(4), .NUM_ADDRESSES(32), .DATA_WIDTH(32),
        .RESET_VALUE(32'h0), .RO_MASK(32'h0000_0004)
    ) dut_a (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
        .i_req_write(req_write), .i_address(address), .i_write_data(write_data),
        .i_write_strobe(write_strobe), .o_resp_valid(a_resp_valid), .i_resp_ready(resp_ready),
        .o_resp_data(a_resp_data), .o_resp_error(a_resp_error), .o_reg_values(a_reg_values),
        .o_write_pulse(a_write_pulse)
    );

    address_decode_regbank #(
        .OFFSET(32'h100), .ADDRESS_STEP(4), .NUM_ADDRESSES(4), .DATA_WIDTH(32),
        .RESET_VALUE(32'hA5A5_0000), .RO_MASK(4'h0)
    ) dut_b (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
        .i_req_write(req_write), .i_address(address), .i_write_data(write_data),
        .i_write_strobe(write_strobe), .o_resp_valid(b_resp_valid), .i_resp_ready(resp_ready),
        .o_resp_data(b_resp_data), .o_resp_error(b_resp_error), .o_reg_values(b_reg_values),
        .o_write_pulse(b_write_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] a_reg(input int i);
        return a_reg_values[i*32 +: 32];
    endfunction

    // Issue one request with resp_ready high; captures the response one step after the accept edge.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
        int n = 0;
        req_write    = wr;
        address      = addr;
        write_data   = data;
        write_strobe = strb;
        resp_ready   = 1'b1;
        while (!a_req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) check("req_ready_timeout", 64'(a_req_ready), 64'd1);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        c_a_valid = a_resp_valid;
        c_a_data  = a_resp_data;
        c_a_err   = a_resp_error;
        c_a_pulse = a_write_pulse;
        c_b_data  = b_resp_data;
        c_b_err   = b_resp_error;
        check("resp_valid_after_accept", 64'(c_a_valid), 64'd1);
        @(posedge clk); #1;
        check("pulse_cleared", 64'(a_write_pulse), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; address = '0;
        write_data = '0; write_strobe = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state and first read
        check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("rst_req_ready", 64'(a_req_ready), 64'd1);
        check("rst_pulse", 64'(a_write_pulse), 64'd0);
        check("rst_resp_data", 64'(a_resp_data), 64'd0);
        check("rst_resp_error", 64'(a_resp_error), 64'd0);
        for (int i = 0; i < 32; i++) check("rst_reg_a", 64'(a_reg(i)), 64'd0);
        for (int i = 0; i < 4; i++) check("rst_reg_b", 64'(b_reg_values[i*32 +: 32]), 64'hA5A5_0000);
        txn(1'b0, 32'h00, 32'h0, 4'h0);
        check("rd0_data", 64'(c_a_data), 64'd0);
        check("rd0_err", 64'(c_a_err), 64'd0);

        // 2: full write then read back
        txn(1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF);
        check("wr3_err", 64'(c_a_err), 64'd0);
        check("wr3_data", 64'(c_a_data), 64'd0);
        check("wr3_pulse", 64'(c_a_pulse), 64'h8);
        check("wr3_reg", 64'(a_reg(3)), 64'hDEAD_BEEF);
        txn(1'b0, 32'h0C, 32'h0, 4'h0);
        check("rd3_data", 64'(c_a_data), 64'hDEAD_BEEF);
        check("rd3_err", 64'(c_a_err), 64'd0);

        // 3: partial strobe
        txn(1'b1, 32'h0C, 32'h1122_3344, 4'h5);
        check("wr3p_pulse", 64'(c_a_pulse), 64'h8);
        check("wr3p_reg", 64'(a_reg(3)), 64'hDE22_BE44);

        // 4: misses
        txn(1'b0, 32'h0E, 32'h0, 4'h0);
        check("mis_err", 64'(c_a_err), 64'd1);
        check("mis_data", 64'(c_a_data), 64'd0);
        txn(1'b1, 32'h0E, 32'hFFFF_FFFF, 4'hF);
        check("mis_wr_err", 64'(c_a_err), 64'd1);
        check("mis_wr_pulse", 64'(c_a_pulse), 64'd0);
        check("mis_wr_reg3", 64'(a_reg(3)), 64'hDE22_BE44);
        txn(1'b0, 32'h80, 32'h0, 4'h0);
        check("oor_err", 64'(c_a_err), 64'd1);
        txn(1'b0, 32'h7C, 32'h0, 4'h0);
        check("last_err", 64'(c_a_err), 64'd0);
        check("last_data", 64'(c_a_data), 64'd0);
        txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        check("huge_err", 64'(c_a_err), 64'd1);
        txn(1'b0, 32'hFC, 32'h0, 4'h0);
        check("b_below_err", 64'(c_b_err), 64'd1);
        check("b_below_data", 64'(c_b_data), 64'd0);
        txn(1'b0, 32'h100, 32'h0, 4'h0);
        check("b_first_err", 64'(c_b_err), 64'd0);
        check("b_first_data", 64'(c_b_data), 64'hA5A5_0000);
        txn(1'b0, 32'h10C, 32'h0, 4'h0);
        check("b_last_err", 64'(c_b_err), 64'd0);
        txn(1'b0, 32'h110, 32'h0, 4'h0);
        check("b_past_err", 64'(c_b_err), 64'd1);

        // 5: read-only register, zero-strobe write, back-pressure
        txn(1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF);
        check("ro_err", 64'(c_a_err), 64'd1);
        check("ro_pulse", 64'(c_a_pulse), 64'd0);
        check("ro_reg2", 64'(a_reg(2)), 64'd0);
        txn(1'b0, 32'h08, 32'h0, 4'h0);
        check("ro_rd_err", 64'(c_a_err), 64'd0);
        txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
        check("zs_pulse", 64'(c_a_pulse), 64'h10);
        check("zs_err", 64'(c_a_err), 64'd0);
        check("zs_reg4", 64'(a_reg(4)), 64'd0);

        req_write = 1'b0; address = 32'h0C; resp_ready = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_write = 1'b1; address = 32'h0C; write_data = 32'h0; write_strobe = 4'hF;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(a_resp_valid), 64'd1);
            check("bp_data", 64'(a_resp_data), 64'hDE22_BE44);
            check("bp_ready", 64'(a_req_ready), 64'd0);
            @(posedge clk); #1;
        end
        check("bp_reg3", 64'(a_reg(3)), 64'hDE22_BE44);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(a_resp_valid), 64'd0);
        check("bp_release_ready", 64'(a_req_ready), 64'd1);

        // 6: reset while a response is pending
        req_write = 1'b1; address = 32'h14; write_data = 32'h55; write_strobe = 4'hF;
        resp_ready = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_valid", 64'(a_resp_valid), 64'd1);
        check("pre_rst_reg5", 64'(a_reg(5)), 64'h55);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_valid", 64'(a_resp_valid), 64'd0);
        check("rst_mid_ready", 64'(a_req_ready), 64'd1);
        check("rst_mid_reg3", 64'(a_reg(3)), 64'd0);
        check("rst_mid_reg5", 64'(a_reg(5)), 64'd0);
        check("rst_mid_pulse", 64'(a_write_pulse), 64'd0);

        // Write presented during the reset cycle must be discarded
        req_write = 1'b1; address = 32'h18; write_data = 32'h77; write_strobe = 4'hF;
        req_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        check("rst_wr_reg6", 64'(a_reg(6)), 64'd0);
        check("rst_wr_valid", 64'(a_resp_valid), 64'd0);
        check("rst_wr_pulse", 64'(a_write_pulse), 64'd0);
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
